// File: rtl/pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_pkg
//  Description : Shared definitions for the packet CRC checker and the
//                transmit-side framer. Holds the word field positions, the
//                trailer status codes, the CRC-8 word function and the
//                framing FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package pkt_pkg;

    // Word field positions (absolute bit indices in a 32-bit word)
    localparam int LEN_MSB  = 31;
    localparam int LEN_LSB  = 28;
    localparam int STAT_MSB = 31;
    localparam int STAT_LSB = 24;
    localparam int CRC_MSB  = 7;
    localparam int CRC_LSB  = 0;

    // Trailer status codes; a word may carry ST_CRC | ST_RSV
    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CRC = 8'h01;
    localparam logic [7:0] ST_RSV = 8'h02;

    // Framing state: header, payload, trailer
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        TRL  = 2'd2
    } pkt_state_e;

    // CRC-8, polynomial 0x07, no reflection, no final XOR.
    // Advances crc_in over one 32-bit word, most significant bit first.
    function automatic logic [7:0] crc8_w32(input logic [7:0]  crc_in,
                                            input logic [31:0] word);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ word[i];
            c  = {c[6:0], 1'b0};
            if (fb) begin
                c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk, rst_n (sync, active-low), inc_i (count enable),
//                cnt_o (current count)
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (inc_i && (r_cnt_q != {WIDTH{1'b1}})) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign cnt_o = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/pkt_crc_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_crc_checker
//  Description : Link ingress stage ahead of the store-and-forward FIFO.
//                Tracks header/payload/trailer framing, recomputes CRC-8
//                over header and payload, rewrites the trailer status byte
//                and forwards every word through a single output register.
//                Keeps saturating good/bad packet counters.
//  Ports       : clk, rst_n (sync, active-low)
//                in_valid_i / in_ready_o / in_data_i : link word handshake
//                full_i                              : FIFO full flag
//                wren_o / wdata_o                    : FIFO write port
//                pkt_ok_cnt_o / pkt_err_cnt_o        : packet statistics
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_crc_checker
    import pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  full_i,
    output logic                  wren_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [CNT_WIDTH-1:0]  pkt_ok_cnt_o,
    output logic [CNT_WIDTH-1:0]  pkt_err_cnt_o
);

    pkt_state_e            r_state_q, w_state_d;
    logic [7:0]            r_crc_q,   w_crc_d;
    logic [3:0]            r_rem_q,   w_rem_d;
    logic                  r_vld_q,   w_vld_d;
    logic                  r_trl_q,   w_trl_d;
    logic [DATA_WIDTH-1:0] r_data_q,  w_data_d;

    logic                  w_accept;
    logic                  w_wren;
    logic [7:0]            w_crc_word;
    logic [7:0]            w_status;
    logic [DATA_WIDTH-1:0] w_proc;
    logic                  w_proc_trl;

    assign w_wren     = r_vld_q & ~full_i;
    assign in_ready_o = ~r_vld_q | ~full_i;
    assign w_accept   = in_valid_i & in_ready_o;

    // A header always restarts the CRC from zero, so the running value is
    // ignored there even if a previous packet left something behind.
    assign w_crc_word = crc8_w32((r_state_q == HDR) ? 8'h00 : r_crc_q, in_data_i);

    always_comb begin
        w_status = ST_OK;
        if (r_crc_q != in_data_i[CRC_MSB:CRC_LSB]) begin
            w_status = w_status | ST_CRC;
        end
        if (|in_data_i[STAT_MSB:STAT_LSB]) begin
            w_status = w_status | ST_RSV;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_crc_d    = r_crc_q;
        w_rem_d    = r_rem_q;
        w_proc     = in_data_i;
        w_proc_trl = 1'b0;

        case (r_state_q)
            HDR: begin
                if (w_accept) begin
                    w_crc_d   = w_crc_word;
                    w_rem_d   = in_data_i[LEN_MSB:LEN_LSB];
                    w_state_d = (in_data_i[LEN_MSB:LEN_LSB] == 4'd0) ? TRL : BODY;
                end
            end
            BODY: begin
                if (w_accept) begin
                    w_crc_d = w_crc_word;
                    w_rem_d = r_rem_q - 4'd1;
                    if (r_rem_q == 4'd1) begin
                        w_state_d = TRL;
                    end
                end
            end
            TRL: begin
                w_proc     = {w_status, in_data_i[STAT_LSB-1:0]};
                w_proc_trl = 1'b1;
                if (w_accept) begin
                    w_crc_d   = 8'h00;
                    w_state_d = HDR;
                end
            end
            default: begin
                w_state_d = HDR;
            end
        endcase
    end

    // Output register: load on accept (which may coincide with a write),
    // otherwise empty it once its word has gone to the FIFO.
    always_comb begin
        w_vld_d  = r_vld_q;
        w_data_d = r_data_q;
        w_trl_d  = r_trl_q;
        if (w_accept) begin
            w_vld_d  = 1'b1;
            w_data_d = w_proc;
            w_trl_d  = w_proc_trl;
        end else if (w_wren) begin
            w_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= HDR;
            r_crc_q   <= 8'h00;
            r_rem_q   <= 4'd0;
            r_vld_q   <= 1'b0;
            r_trl_q   <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_crc_q   <= w_crc_d;
            r_rem_q   <= w_rem_d;
            r_vld_q   <= w_vld_d;
            r_trl_q   <= w_trl_d;
            r_data_q  <= w_data_d;
        end
    end

    // The FIFO shares rst_n, so a word still held here when reset arrives is
    // discarded rather than presented as a write during the reset cycle.
    assign wren_o  = w_wren & rst_n;
    assign wdata_o = r_data_q;

    logic w_ok_inc;
    logic w_err_inc;

    assign w_ok_inc  = w_wren & r_trl_q & (r_data_q[STAT_MSB:STAT_LSB] == ST_OK);
    assign w_err_inc = w_wren & r_trl_q & (r_data_q[STAT_MSB:STAT_LSB] != ST_OK);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_ok_inc),
        .cnt_o (pkt_ok_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_err_inc),
        .cnt_o (pkt_err_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pkt_crc_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_crc_checker
//  Description : Directed bench for pkt_crc_checker. Expected FIFO words are
//                queued as the link accepts them and compared as the DUT
//                writes them; counters are compared after each drain.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pkt_crc_checker;

    // Narrow counters keep the saturation run short.
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'h0;
    logic          full = 1'b0;
    logic          wren;
    logic [31:0]   wdata;
    logic [CW-1:0] ok_cnt;
    logic [CW-1:0] err_cnt;

    logic [31:0] sb[$];
    int          n_asserts = 0;
    int          n_fail    = 0;
    int          full_left = 0;
    int          exp_ok    = 0;
    int          exp_err   = 0;
    int          n_writes  = 0;

    pkt_crc_checker #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .full_i        (full),
        .wren_o        (wren),
        .wdata_o       (wdata),
        .pkt_ok_cnt_o  (ok_cnt),
        .pkt_err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference CRC: long division of the augmented word by x^8+x^2+x+1,
    // with the running CRC folded into the top byte of the word.
    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [31:0] w);
        logic [39:0] v;
        v = {({c, 24'h0} ^ w), 8'h00};
        for (int i = 39; i >= 8; i--) begin
            if (v[i]) begin
                v[i-:9] = v[i-:9] ^ 9'h107;
            end
        end
        return v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // FIFO-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("no_wren_in_reset", 32'(wren), 32'h0);
        end else if (wren) begin
            chk("no_wren_when_full", 32'(full), 32'h0);
            n_writes++;
            if (sb.size() == 0) begin
                chk("unexpected_write", wdata, 32'hxxxx_xxxx);
            end else begin
                chk("wdata", wdata, sb.pop_front());
            end
        end
    end

    // One clock: full is updated just after the rising edge, and the task
    // returns on the falling edge where inputs are changed and sampled.
    task automatic tick();
        @(posedge clk);
        #1;
        full = (full_left > 0);
        if (full_left > 0) full_left--;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] e);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_data  = w;
        guard    = 0;
        do begin
            acc = in_ready;
            if (acc) sb.push_back(e);
            tick();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("accept_timeout", 32'(acc), 32'h1);
    endtask

    // Sends one packet; bp_at >= 0 raises full for 3 cycles right after
    // payload word bp_at is accepted.
    task automatic send_pkt(input logic [3:0] len, input logic [27:0] hdr_lo,
                            input logic [31:0] seed, input logic [15:0] trl_mid,
                            input logic [7:0] crc_xor, input logic [7:0] rsv,
                            input int bp_at);
        logic [31:0] w;
        logic [7:0]  c;
        logic [7:0]  st;
        w = {len, hdr_lo};
        c = ref_crc(8'h00, w);
        send_word(w, w);
        for (int i = 0; i < int'(len); i++) begin
            w = seed + 32'(i);
            c = ref_crc(c, w);
            if (i == bp_at) full_left = 3;
            send_word(w, w);
            if (i == bp_at) chk("bp_ready_low", 32'(in_ready), 32'h0);
        end
        w  = {rsv, trl_mid, c ^ crc_xor};
        st = {6'b0, (rsv != 8'h00), (crc_xor != 8'h00)};
        send_word(w, {st, w[23:0]});
        if (st == 8'h00) begin
            if (exp_ok < CNT_MAX) exp_ok++;
        end else begin
            if (exp_err < CNT_MAX) exp_err++;
        end
    endtask

    task automatic drain_check(input string tag, input int writes_before, input int exp_writes);
        idle(4);
        chk({tag, "_writes"},  32'(n_writes - writes_before), 32'(exp_writes));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
        chk({tag, "_ok_cnt"},  32'(ok_cnt),  32'(exp_ok));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    int wb;

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_wren",     32'(wren),     32'h0);
        chk("rst_wdata",    wdata,         32'h0);
        chk("rst_ok_cnt",   32'(ok_cnt),   32'h0);
        chk("rst_err_cnt",  32'(err_cnt),  32'h0);
        rst_n = 1'b1;
        tick();

        // Good packet, len=3
        wb = n_writes;
        send_pkt(4'd3, 28'h0, 32'h1, 16'h0000, 8'h00, 8'h00, -1);
        drain_check("good", wb, 5);

        // Same packet with a corrupted CRC
        wb = n_writes;
        send_pkt(4'd3, 28'h0, 32'h1, 16'h0000, 8'h01, 8'h00, -1);
        drain_check("bad_crc", wb, 5);

        // len=0: header and trailer of zeros
        wb = n_writes;
        send_pkt(4'd0, 28'h0, 32'h0, 16'h0000, 8'h00, 8'h00, -1);
        drain_check("len0", wb, 2);

        // Back-pressure mid-payload, nonzero pass-through trailer bits
        wb = n_writes;
        send_pkt(4'd4, 28'h0ABCDEF, 32'hDEAD_0100, 16'hBEEF, 8'h00, 8'h00, 1);
        drain_check("backpressure", wb, 6);

        // Reserved trailer field fault with a correct CRC
        wb = n_writes;
        send_pkt(4'd2, 28'h1234567, 32'h5555_AAAA, 16'h1357, 8'h00, 8'hAA, -1);
        drain_check("rsv_fault", wb, 4);

        // Reset after header and one payload word
        send_word({4'd3, 28'h0}, {4'd3, 28'h0});
        send_word(32'h0000_0001, 32'h0000_0001);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_ok   = 0;
        exp_err  = 0;
        repeat (3) tick();
        chk("mid_rst_ok_cnt",  32'(ok_cnt),  32'h0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;
        tick();
        wb = n_writes;
        send_pkt(4'd3, 28'h0, 32'h1, 16'h0000, 8'h00, 8'h00, -1);
        drain_check("after_rst", wb, 5);

        // Saturation of the good counter
        for (int p = 0; p < CNT_MAX + 1; p++) begin
            send_pkt(4'd0, 28'(p), 32'h0, 16'(p * 3), 8'h00, 8'h00, -1);
        end
        idle(4);
        chk("sat_ok_cnt",  32'(ok_cnt),  32'(CNT_MAX));
        chk("sat_err_cnt", 32'(err_cnt), 32'h0);
        chk("sat_sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
